fetch_decode_queue: RTL and testbench

- Parametrised successor to the single fetch→decode pipeline register.
- Replaces it with a DEPTH-entry instruction/PC FIFO carrying a valid/ready handshake, so fetch can run ahead while decode is stalled.
- Sits between the fetch and decode stages.
- Flush empties the queue in one cycle. An empty queue presents a bubble (instr = NOP opcode 0) to decode.

---
 rtl/fetch_decode_queue_pkg.sv | 10 +
 rtl/fetch_decode_queue_storage.sv | 26 ++
 rtl/fetch_decode_queue.sv | 63 ++++++
 tb/tb_fetch_decode_queue.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/fetch_decode_queue_pkg.sv
// fetch_decode_queue_pkg: shared pipeline widths, NOP opcode and queue entry type
package fetch_decode_queue_pkg;
  localparam int DEF_INSTR_W = 32;
  localparam int DEF_PC_W = 32;
  localparam logic [DEF_INSTR_W-1:0] NOP_INSTR = '0;
  typedef struct packed {
    logic [DEF_INSTR_W-1:0] instr;
    logic [DEF_PC_W-1:0] pc;
  } fdq_entry_t;
endpackage

// File: rtl/fetch_decode_queue_storage.sv
// fetch_queue_storage: DEPTH x W register array, one write port, async read port
module fetch_queue_storage #(
  parameter int DEPTH = 4,
  parameter int W = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);
  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  // next array contents: write the addressed entry when enabled
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end
  // storage registers, cleared on reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) mem_q <= '0;
    else mem_q <= mem_d;
  end
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue: DEPTH-entry instr/PC FIFO between fetch and decode with flush
module fetch_decode_queue
  import fetch_decode_queue_pkg::*;
#(
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int PC_W = DEF_PC_W,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       f_valid,
  input  logic [INSTR_W-1:0]         f_instr,
  input  logic [PC_W-1:0]            f_pc,
  output logic                       f_ready,
  input  logic                       f_flush,
  input  logic                       d_stall,
  output logic                       d_valid,
  output logic [INSTR_W-1:0]         d_instr,
  output logic [PC_W-1:0]            d_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic push, pop;
  logic [INSTR_W-1:0] rd_instr;
  logic [PC_W-1:0] rd_pc;
  assign f_ready = count_q != CW'(DEPTH);
  assign d_valid = count_q != '0;
  assign push = f_valid & f_ready & ~f_flush;
  assign pop = d_valid & ~d_stall & ~f_flush;
  // pointer and occupancy update; flush returns everything to empty
  always_comb begin
    wr_ptr_d = f_flush ? '0 : wr_ptr_q + AW'(push);
    rd_ptr_d = f_flush ? '0 : rd_ptr_q + AW'(pop);
    count_d = f_flush ? '0 : count_q + CW'(push) - CW'(pop);
  end
  // pointer and occupancy registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  fetch_queue_storage #(.DEPTH(DEPTH), .W(INSTR_W + PC_W)) u_storage (
    .clock(clock),
    .reset(reset),
    .we(push),
    .waddr(wr_ptr_q),
    .wdata({f_instr, f_pc}),
    .raddr(rd_ptr_q),
    .rdata({rd_instr, rd_pc})
  );
  assign d_instr = d_valid ? rd_instr : INSTR_W'(NOP_INSTR);
  assign d_pc = d_valid ? rd_pc : '0;
  assign count = count_q;
endmodule

// File: tb/tb_fetch_decode_queue.sv
// tb_fetch_decode_queue: directed tests against a queue-based reference model
module tb_fetch_decode_queue;
  import fetch_decode_queue_pkg::*;
  logic clock = 0, reset = 1;
  logic f_valid = 0, f_flush = 0, d_stall = 0;
  logic [31:0] f_instr = 0, f_pc = 0;
  logic f_ready, d_valid;
  logic [31:0] d_instr, d_pc;
  logic [2:0] count;
  int checks = 0, errors = 0;
  fdq_entry_t mq[$];
  logic [31:0] dut_out[$];

  fetch_decode_queue #(.INSTR_W(32), .PC_W(32), .DEPTH(4)) dut (
    .clock(clock), .reset(reset), .f_valid(f_valid), .f_instr(f_instr), .f_pc(f_pc),
    .f_ready(f_ready), .f_flush(f_flush), .d_stall(d_stall), .d_valid(d_valid),
    .d_instr(d_instr), .d_pc(d_pc), .count(count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #2;
  endtask

  // reference model: a plain FIFO of entries with the handshake rules
  always @(posedge clock or posedge reset) begin
    if (reset) mq.delete();
    else if (f_flush) mq.delete();
    else begin
      automatic bit pu = f_valid && mq.size() < 4;
      automatic bit po = mq.size() > 0 && !d_stall;
      if (po) void'(mq.pop_front());
      if (pu) mq.push_back('{instr: f_instr, pc: f_pc});
    end
  end

  // per-cycle comparison against the model and log of delivered PCs
  always @(negedge clock) begin
    if (!reset) begin
      chk("d_valid", d_valid, mq.size() != 0);
      chk("d_instr", d_instr, mq.size() != 0 ? mq[0].instr : 32'h0);
      chk("d_pc", d_pc, mq.size() != 0 ? mq[0].pc : 32'h0);
      chk("f_ready", f_ready, mq.size() != 4);
      chk("count", count, mq.size());
      if (d_valid && !d_stall && !f_flush) dut_out.push_back(d_pc);
    end
  end

  initial begin
    int sent;
    repeat (2) @(posedge clock);
    #2 reset = 0;
    chk("rst_d_valid", d_valid, 0);
    chk("rst_d_instr", d_instr, 0);
    chk("rst_d_pc", d_pc, 0);
    chk("rst_f_ready", f_ready, 1);
    chk("rst_count", count, 0);
    step();
    f_valid = 1; f_instr = 32'hA1; f_pc = 32'h100;
    step();
    f_valid = 0;
    chk("one_valid", d_valid, 1);
    chk("one_instr", d_instr, 32'hA1);
    chk("one_pc", d_pc, 32'h100);
    step();
    chk("one_empty", d_valid, 0);
    chk("one_count", count, 0);
    d_stall = 1;
    for (int i = 0; i < 4; i++) begin
      f_valid = 1; f_instr = 32'h10 + i; f_pc = i * 4;
      step();
    end
    chk("full_count", count, 4);
    chk("full_ready", f_ready, 0);
    f_pc = 32'h10; f_instr = 32'h14;
    step();
    f_valid = 0;
    chk("full_reject", count, 4);
    dut_out.delete();
    d_stall = 0;
    repeat (4) step();
    chk("drain_n", dut_out.size(), 4);
    for (int i = 0; i < 4 && i < dut_out.size(); i++) chk("drain_pc", dut_out[i], i * 4);
    chk("drain_count", count, 0);
    dut_out.delete();
    sent = 0;
    for (int c = 0; c < 100 && (sent < 10 || dut_out.size() < 10); c++) begin
      d_stall = ((c / 3) % 2) == 1;
      f_valid = sent < 10; f_instr = 32'hB0 + sent; f_pc = 32'h200 + sent * 4;
      #1;
      if (f_valid && f_ready) sent++;
      step();
    end
    f_valid = 0; d_stall = 0;
    chk("stream_sent", sent, 10);
    chk("stream_n", dut_out.size(), 10);
    for (int i = 0; i < 10 && i < dut_out.size(); i++) chk("stream_pc", dut_out[i], 32'h200 + i * 4);
    step();
    d_stall = 1;
    for (int i = 0; i < 3; i++) begin
      f_valid = 1; f_instr = 32'h40 + i; f_pc = 32'h400 + i * 4;
      step();
    end
    chk("pre_flush_count", count, 3);
    dut_out.delete();
    f_flush = 1; f_valid = 1; f_instr = 32'hFF; f_pc = 32'hDEAD; d_stall = 0;
    step();
    f_flush = 0; f_valid = 0;
    chk("flush_count", count, 0);
    chk("flush_valid", d_valid, 0);
    chk("flush_instr", d_instr, 0);
    repeat (3) step();
    chk("flush_leak", dut_out.size(), 0);
    d_stall = 1;
    for (int i = 0; i < 2; i++) begin
      f_valid = 1; f_instr = 32'h50 + i; f_pc = 32'h500 + i * 4;
      step();
    end
    f_valid = 0;
    chk("pre_rst_count", count, 2);
    #1 reset = 1;
    #1;
    chk("arst_valid", d_valid, 0);
    chk("arst_instr", d_instr, 0);
    chk("arst_pc", d_pc, 0);
    chk("arst_count", count, 0);
    chk("arst_ready", f_ready, 1);
    step();
    reset = 0; d_stall = 0;
    f_valid = 1; f_instr = 32'hC3; f_pc = 32'h300;
    step();
    f_valid = 0;
    chk("post_rst_pc", d_pc, 32'h300);
    chk("post_rst_instr", d_instr, 32'hC3);
    chk("post_rst_count", count, 1);
    repeat (2) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
